tlp_tx_arb: RTL and testbench

- Packet-atomic round-robin arbiter that shares one TLP transmit path between two TLP sources.
- Example sources: the read-completion generator and the write-response generator, both sitting behind the read/write demux.
- The grant is held from sop to eop, so the beats of two TLPs never interleave.
- The output is a single registered stage that feeds the PCIe TX interface.

---
 rtl/tlp_tx_arb_if.sv | 15 +
 rtl/tlp_tx_arb.sv | 123 ++++++++++++
 tb/tb_tlp_tx_arb.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlp_tx_arb_if.sv
// TLP beat stream bundle: payload, header, framing and a valid/ready handshake.
interface tlp_tx_arb_if #(
    parameter int HEADER_SIZE  = 128,
    parameter int PAYLOAD_SIZE = 256
);
    logic [PAYLOAD_SIZE-1:0] data;
    logic [HEADER_SIZE-1:0]  hdr;
    logic                    sop;
    logic                    eop;
    logic                    valid;
    logic                    ready;

    modport master (output data, hdr, sop, eop, valid, input ready);
    modport slave  (input data, hdr, sop, eop, valid, output ready);
endinterface

// File: rtl/tlp_tx_arb.sv
// Packet-atomic two-port TLP arbiter feeding one registered TX stage.
// Define TLP_TX_ARB_FIXED_PRIO_EN to make port 0 win every IDLE contest instead of round-robin.
module tlp_tx_arb #(
    parameter int DOUBLE_WORD  = 32,
    parameter int HEADER_SIZE  = 4*DOUBLE_WORD,
    parameter int PAYLOAD_SIZE = 8*DOUBLE_WORD,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    tlp_tx_arb_if.slave      in0,
    tlp_tx_arb_if.slave      in1,
    tlp_tx_arb_if.master     out,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic             sop_err
);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t                  state, state_n;
    logic                    last, last_n;
    logic                    rdy0, rdy1, sel1, pick1, drop;
    logic                    req0, req1, can_take, take0, take1;
    logic [PAYLOAD_SIZE-1:0] data_q;
    logic [HEADER_SIZE-1:0]  hdr_q;
    logic                    sop_q, eop_q, valid_q;

    assign can_take = !valid_q | out.ready;
    assign req0     = in0.valid & in0.sop & enable;
    assign req1     = in1.valid & in1.sop & enable;

    always_comb begin
        state_n = state;
        last_n  = last;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        sel1    = 1'b0;
        pick1   = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
`ifdef TLP_TX_ARB_FIXED_PRIO_EN
                    pick1 = !req0;
`else
                    pick1 = req1 & (!req0 | !last);
`endif
                    sel1 = pick1;
                    rdy0 = !pick1 & can_take;
                    rdy1 = pick1 & can_take;
                    if (can_take) begin
                        last_n = pick1;
                        // A single-beat TLP never takes the lock
                        if (!(pick1 ? in1.eop : in0.eop))
                            state_n = pick1 ? LOCK1 : LOCK0;
                    end
                end else if (enable & in0.valid & !in0.sop) begin
                    rdy0 = 1'b1;
                    drop = 1'b1;
                end else if (enable & in1.valid & !in1.sop) begin
                    rdy1 = 1'b1;
                    drop = 1'b1;
                end
            end
            LOCK0: begin
                rdy0 = can_take;
                if (in0.valid & can_take & in0.eop) state_n = IDLE;
            end
            LOCK1: begin
                sel1 = 1'b1;
                rdy1 = can_take;
                if (in1.valid & can_take & in1.eop) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Dropped stray beats are handshaken but never forwarded or counted
    assign take0 = in0.valid & rdy0 & !drop;
    assign take1 = in1.valid & rdy1 & !drop;

    assign in0.ready = rdy0;
    assign in1.ready = rdy1;
    assign grant     = {state == LOCK1, state == LOCK0};

    assign out.data  = data_q;
    assign out.hdr   = hdr_q;
    assign out.sop   = sop_q;
    assign out.eop   = eop_q;
    assign out.valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            data_q   <= '0;
            hdr_q    <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            valid_q  <= 1'b0;
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
            sop_err  <= 1'b0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            sop_err <= drop;
            if (take0 & in0.eop) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
            if (take1 & in1.eop) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
            if (take0 | take1) begin
                data_q  <= sel1 ? in1.data : in0.data;
                hdr_q   <= sel1 ? in1.hdr  : in0.hdr;
                sop_q   <= sel1 ? in1.sop  : in0.sop;
                eop_q   <= sel1 ? in1.eop  : in0.eop;
                valid_q <= 1'b1;
            end else if (out.ready) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tlp_tx_arb.sv
// Scoreboard bench for tlp_tx_arb: predicted beat order is queued as stimulus is issued.
module tb_tlp_tx_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [1:0]  grant;
    logic [15:0] pkt_cnt0, pkt_cnt1;
    logic        sop_err;

    tlp_tx_arb_if #(.HEADER_SIZE(128), .PAYLOAD_SIZE(256)) i0 ();
    tlp_tx_arb_if #(.HEADER_SIZE(128), .PAYLOAD_SIZE(256)) i1 ();
    tlp_tx_arb_if #(.HEADER_SIZE(128), .PAYLOAD_SIZE(256)) o  ();

    tlp_tx_arb dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in0(i0), .in1(i1), .out(o),
        .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .sop_err(sop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [127:0] hdr;
        logic         sop;
        logic         eop;
    } beat_t;

    beat_t exp_q[$];
    int    pop_cyc[$];
    int    n_chk = 0, n_bad = 0, cyc = 0;
    int    exp_cnt0 = 0, exp_cnt1 = 0;
    logic  mlast = 1'b1;
    logic  bulk = 1'b0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mkdata(input int p, input int id, input int b);
        return {32'hD000_0000 | 32'(p << 16) | 32'(id << 8) | 32'(b), 224'(id * 31 + b * 7 + p)};
    endfunction

    function automatic logic [127:0] mkhdr(input int p, input int id);
        return {32'h4000_0000 | 32'(p << 8) | 32'(id), 96'(id * 13 + p)};
    endfunction

    task automatic push_pkt(input int p, input int n, input int id);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt.data = mkdata(p, id, b);
            bt.hdr  = mkhdr(p, id);
            bt.sop  = (b == 0);
            bt.eop  = (b == n - 1);
            exp_q.push_back(bt);
        end
        if (p == 0) exp_cnt0++; else exp_cnt1++;
        mlast = (p != 0);
    endtask

    task automatic drive(input int p, input logic v, input logic s, input logic e,
                         input logic [255:0] d, input logic [127:0] h);
        if (p == 0) begin
            i0.valid = v; i0.sop = s; i0.eop = e; i0.data = d; i0.hdr = h;
        end else begin
            i1.valid = v; i1.sop = s; i1.eop = e; i1.data = d; i1.hdr = h;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the last beat
    task automatic send_pkt(input int p, input int n, input int id);
        logic acc;
        int   t;
        for (int b = 0; b < n; b++) begin
            drive(p, 1'b1, b == 0, b == n - 1, mkdata(p, id, b), mkhdr(p, id));
            acc = 1'b0;
            t = 0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = (p == 0) ? i0.ready : i1.ready;
                t++;
            end
            if (!acc) begin
                check_val("send_timeout", 256'(0), 256'(1));
                drive(p, 1'b0, 1'b0, 1'b0, '0, '0);
                return;
            end
            @(posedge clk);
            #1;
        end
        drive(p, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!bulk && rst_n && o.valid && o.ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat", o.data, 256'(0));
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check_val("out_data", o.data, e.data);
                check_val("out_hdr", 256'(o.hdr), 256'(e.hdr));
                check_val("out_sop", 256'(o.sop), 256'(e.sop));
                check_val("out_eop", 256'(o.eop), 256'(e.eop));
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        int mark, nb;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        o.ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", 256'(o.valid), 256'(0));
        check_val("rst_grant", 256'(grant), 256'(0));
        check_val("rst_cnt0", 256'(pkt_cnt0), 256'(0));
        check_val("rst_sop_err", 256'(sop_err), 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-beat TLP on port 0
        push_pkt(0, 1, 1);
        drive(0, 1'b1, 1'b1, 1'b1, mkdata(0, 1, 0), mkhdr(0, 1));
        @(negedge clk);
        check_val("s1_ready0", 256'(i0.ready), 256'(1));
        check_val("s1_valid_pre", 256'(o.valid), 256'(0));
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check_val("s1_valid", 256'(o.valid), 256'(1));
        check_val("s1_hdr", 256'(o.hdr), 256'(mkhdr(0, 1)));
        check_val("s1_cnt0", 256'(pkt_cnt0), 256'(1));
        check_val("s1_grant", 256'(grant), 256'(0));
        @(posedge clk); #1;

        // Two 3-beat TLPs per port contending
        mark = pop_cyc.size();
`ifdef TLP_TX_ARB_FIXED_PRIO_EN
        push_pkt(0, 3, 10); push_pkt(0, 3, 12); push_pkt(1, 3, 11); push_pkt(1, 3, 13);
`else
        if (mlast) begin
            push_pkt(0, 3, 10); push_pkt(1, 3, 11); push_pkt(0, 3, 12); push_pkt(1, 3, 13);
        end else begin
            push_pkt(1, 3, 11); push_pkt(0, 3, 10); push_pkt(1, 3, 13); push_pkt(0, 3, 12);
        end
`endif
        fork
            begin send_pkt(0, 3, 10); send_pkt(0, 3, 12); end
            begin send_pkt(1, 3, 11); send_pkt(1, 3, 13); end
        join
        repeat (3) @(posedge clk); #1;
        check_val("rr_drained", 256'(exp_q.size()), 256'(0));
        if (pop_cyc.size() >= mark + 12)
            check_val("rr_no_gap", 256'(pop_cyc[mark + 11] - pop_cyc[mark]), 256'(11));
        else
            check_val("rr_beats", 256'(pop_cyc.size() - mark), 256'(12));
        check_val("rr_cnt0", 256'(pkt_cnt0), 256'(exp_cnt0));
        check_val("rr_cnt1", 256'(pkt_cnt1), 256'(exp_cnt1));

        // Backpressure mid-packet
        mark = pop_cyc.size();
        push_pkt(0, 4, 20);
        fork
            send_pkt(0, 4, 20);
            begin
                nb = 0;
                while (pop_cyc.size() < mark + 2 && nb < 100) begin @(negedge clk); nb++; end
                @(posedge clk); #1;
                o.ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check_val("bp_valid", 256'(o.valid), 256'(1));
                    check_val("bp_hold", o.data, (exp_q.size() > 0) ? exp_q[0].data : 256'(0));
                    check_val("bp_ready0", 256'(i0.ready), 256'(0));
                end
                @(posedge clk); #1;
                o.ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;
        check_val("bp_drained", 256'(exp_q.size()), 256'(0));
        check_val("bp_beats", 256'(pop_cyc.size() - mark), 256'(4));

        // enable drop during a locked port 1 packet
        push_pkt(1, 4, 30);
        fork
            send_pkt(1, 4, 30);
            begin repeat (2) @(posedge clk); #1; enable = 1'b0; end
        join
        repeat (2) @(posedge clk); #1;
        check_val("en_pkt_done", 256'(pkt_cnt1), 256'(exp_cnt1));
        if (mlast) begin push_pkt(0, 1, 31); push_pkt(1, 1, 32); end
        else begin push_pkt(1, 1, 32); push_pkt(0, 1, 31); end
        fork
            send_pkt(0, 1, 31);
            send_pkt(1, 1, 32);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_val("en_grant", 256'(grant), 256'(0));
                    check_val("en_rdy", 256'({i1.ready, i0.ready}), 256'(0));
                end
                @(posedge clk); #1;
                enable = 1'b1;
                @(negedge clk);
                check_val("en_resume", 256'(i0.ready | i1.ready), 256'(1));
            end
        join
        repeat (3) @(posedge clk); #1;
        check_val("en_drained", 256'(exp_q.size()), 256'(0));

        // Stray non-sop beat on port 1 in IDLE
        mark = pop_cyc.size();
        drive(1, 1'b1, 1'b0, 1'b0, mkdata(1, 40, 0), mkhdr(1, 40));
        @(negedge clk);
        check_val("stray_ready1", 256'(i1.ready), 256'(1));
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check_val("stray_err", 256'(sop_err), 256'(1));
        check_val("stray_no_out", 256'(o.valid), 256'(0));
        @(negedge clk);
        check_val("stray_err_clr", 256'(sop_err), 256'(0));
        check_val("stray_no_pop", 256'(pop_cyc.size() - mark), 256'(0));
        @(posedge clk); #1;

        // Counter wrap on port 0
        bulk = 1'b1;
        nb = 16'hFFFF - exp_cnt0;
        drive(0, 1'b1, 1'b1, 1'b1, '0, '0);
        repeat (nb) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        exp_cnt0 = 16'hFFFF;
        mlast = 1'b0;
        @(negedge clk);
        check_val("cnt0_max", 256'(pkt_cnt0), 256'(16'hFFFF));
        repeat (2) @(posedge clk); #1;
        bulk = 1'b0;
        push_pkt(0, 1, 50);
        send_pkt(0, 1, 50);
        @(negedge clk);
        check_val("cnt0_wrap", 256'(pkt_cnt0), 256'(exp_cnt0 & 16'hFFFF));
        @(posedge clk); #1;
        check_val("wrap_drained", 256'(exp_q.size()), 256'(0));

        // Asynchronous reset in the middle of a packet
        bulk = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, mkdata(0, 60, 0), mkhdr(0, 60));
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 1'b0, mkdata(0, 60, 1), mkhdr(0, 60));
        @(posedge clk); #1;
        check_val("pre_rst_grant", 256'(grant), 256'(1));
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_valid", 256'(o.valid), 256'(0));
        check_val("arst_data", o.data, 256'(0));
        check_val("arst_grant", 256'(grant), 256'(0));
        check_val("arst_cnt", 256'({pkt_cnt1, pkt_cnt0}), 256'(0));
        check_val("arst_err", 256'(sop_err), 256'(0));
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_grant", 256'(grant), 256'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=stuck expected=finish");
        $fatal(1);
    end
endmodule
